// File: rtl/uart_rx_fifo_gen.sv
// UART receive channel: oversampled frame decoder feeding a show-ahead FIFO
// whose entries carry per-character break / framing / parity status.
module uart_rx_fifo_gen #(
    parameter int DATA_MAX      = 9,
    parameter int FIFO_DEPTH    = 16,
    parameter int OVERSAMPLE    = 16,
    parameter int TIMEOUT_CHARS = 4
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic                          BAUD_TICK,
    input  logic                          RX,
    input  logic [3:0]                    DATA_BITS,
    input  logic                          PARITY_EN,
    input  logic                          ODD_N_EVEN,
    input  logic                          STOP2,
    input  logic [$clog2(FIFO_DEPTH):0]   THRESHOLD,
    input  logic                          RD_EN,
    input  logic                          CLR_OVERFLOW,
    output logic [DATA_MAX-1:0]           RD_DATA,
    output logic                          RD_PARITY_ERR,
    output logic                          RD_FRAMING_ERR,
    output logic                          RD_BREAK,
    output logic                          EMPTY,
    output logic                          FULL,
    output logic [$clog2(FIFO_DEPTH):0]   LEVEL,
    output logic                          OVERFLOW,
    output logic                          TIMEOUT,
    output logic                          RXRDY
);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int LW       = AW + 1;
    localparam int SW       = $clog2(OVERSAMPLE);
    localparam int EW       = DATA_MAX + 3;
    localparam int TO_LIMIT = TIMEOUT_CHARS * 10 * OVERSAMPLE;
    localparam int TW       = $clog2(TO_LIMIT + 1);

    localparam logic [3:0]    DMAX4   = 4'(DATA_MAX);
    localparam logic [SW-1:0] HALF_M1 = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] FULL_M1 = SW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TO_LIM  = TW'(TO_LIMIT);
    localparam logic [TW-1:0] TO_LAST = TW'(TO_LIMIT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_BRK_WAIT
    } state_t;

    state_t              r_state, w_next;
    logic                r_rx_meta, r_rxs, r_rxs_d;
    logic [SW-1:0]       r_scnt;
    logic [3:0]          r_nbits, r_bitcnt, w_nbits_cl, w_shamt;
    logic                r_par_en, r_odd, r_stop2;
    logic [DATA_MAX-1:0] r_data, w_dout;
    logic                r_zero, r_pe, r_fe, r_brk;
    logic                w_fall, w_samp, w_last_data, w_push, w_brk, w_fe;
    logic [EW-1:0]       w_entry, w_head;
    logic [EW-1:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]       r_wptr, r_rptr;
    logic [LW-1:0]       r_level, w_level_nx, w_thr;
    logic                r_empty, r_full, r_ovf, r_tmo;
    logic                w_pop, w_wr, w_tinc;
    logic [TW-1:0]       r_tcnt;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
            r_rxs_d   <= 1'b1;
        end else begin
            r_rx_meta <= RX;
            r_rxs     <= r_rx_meta;
            r_rxs_d   <= r_rxs;
        end
    end

    assign w_fall = r_rxs_d & ~r_rxs;
    // Start is sampled mid-bit; every later bit one full bit period on.
    assign w_samp = BAUD_TICK & ((r_state == S_START) ? (r_scnt == HALF_M1) : (r_scnt == FULL_M1));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)                 r_scnt <= '0;
        else if (r_state == S_IDLE)   r_scnt <= '0;
        else if (BAUD_TICK)           r_scnt <= w_samp ? '0 : r_scnt + SW'(1);
    end

    always_comb begin
        w_nbits_cl = DATA_BITS;
        if (DATA_BITS < 4'd5)        w_nbits_cl = 4'd5;
        else if (DATA_BITS > DMAX4)  w_nbits_cl = DMAX4;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_nbits  <= 4'd8;
            r_par_en <= 1'b0;
            r_odd    <= 1'b0;
            r_stop2  <= 1'b0;
            r_data   <= '0;
            r_bitcnt <= '0;
            r_zero   <= 1'b1;
            r_pe     <= 1'b0;
            r_fe     <= 1'b0;
            r_brk    <= 1'b0;
        end else if (r_state == S_IDLE && w_fall) begin
            r_nbits  <= w_nbits_cl;
            r_par_en <= PARITY_EN;
            r_odd    <= ODD_N_EVEN;
            r_stop2  <= STOP2;
            r_data   <= '0;
            r_bitcnt <= '0;
            r_zero   <= 1'b1;
            r_pe     <= 1'b0;
            r_fe     <= 1'b0;
            r_brk    <= 1'b0;
        end else if (w_samp) begin
            case (r_state)
                S_DATA: begin
                    r_data   <= {r_rxs, r_data[DATA_MAX-1:1]};
                    r_bitcnt <= r_bitcnt + 4'd1;
                    if (r_rxs) r_zero <= 1'b0;
                end
                S_PARITY: begin
                    r_pe <= ((^r_data) ^ r_rxs) != r_odd;
                    if (r_rxs) r_zero <= 1'b0;
                end
                S_STOP1: begin
                    r_fe  <= ~r_rxs;
                    r_brk <= r_zero & ~r_rxs;
                end
                default: ;
            endcase
        end
    end

    // LSB-first shifting leaves a short character in the top bits.
    assign w_shamt     = DMAX4 - r_nbits;
    assign w_dout      = r_data >> w_shamt;
    assign w_last_data = (r_bitcnt == r_nbits - 4'd1);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (w_fall) w_next = S_START;
            S_START:    if (w_samp) w_next = r_rxs ? S_IDLE : S_DATA;
            S_DATA:     if (w_samp && w_last_data) w_next = r_par_en ? S_PARITY : S_STOP1;
            S_PARITY:   if (w_samp) w_next = S_STOP1;
            S_STOP1:    if (w_samp) w_next = r_stop2 ? S_STOP2 : (w_brk ? S_BRK_WAIT : S_IDLE);
            S_STOP2:    if (w_samp) w_next = w_brk ? S_BRK_WAIT : S_IDLE;
            S_BRK_WAIT: if (r_rxs) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_push = 1'b0;
        w_brk  = r_brk;
        w_fe   = r_fe | ~r_rxs;
        if (r_state == S_STOP1) begin
            w_brk  = r_zero & ~r_rxs;
            w_fe   = ~r_rxs;
            w_push = w_samp & ~r_stop2;
        end else if (r_state == S_STOP2) begin
            w_push = w_samp;
        end
    end

    assign w_entry    = {w_brk, w_fe, r_pe, w_dout};
    assign w_pop      = RD_EN & ~r_empty;
    assign w_wr       = w_push & (~r_full | w_pop);
    assign w_level_nx = r_level + LW'(w_wr) - LW'(w_pop);

    always_ff @(posedge CLK) begin
        if (w_wr) r_mem[r_wptr] <= w_entry;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_wr)  r_wptr <= r_wptr + AW'(1);
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            r_level <= w_level_nx;
            r_empty <= (w_level_nx == '0);
            r_full  <= (w_level_nx == LW'(FIFO_DEPTH));
            if (w_push & r_full & ~w_pop) r_ovf <= 1'b1;
            else if (CLR_OVERFLOW)        r_ovf <= 1'b0;
        end
    end

    // Idle timer only runs with data waiting and the line quiet.
    assign w_tinc = BAUD_TICK & ~r_empty & (r_state == S_IDLE) & ~w_push & ~w_pop & (r_tcnt != TO_LIM);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_tcnt <= '0;
            r_tmo  <= 1'b0;
        end else begin
            if (w_push | w_pop | (r_state != S_IDLE)) r_tcnt <= '0;
            else if (w_tinc)                          r_tcnt <= r_tcnt + TW'(1);
            if (w_pop | r_empty)                      r_tmo  <= 1'b0;
            else if (w_tinc && r_tcnt == TO_LAST)     r_tmo  <= 1'b1;
        end
    end

    assign w_head         = r_mem[r_rptr];
    assign RD_DATA        = r_empty ? '0 : w_head[DATA_MAX-1:0];
    assign RD_PARITY_ERR  = ~r_empty & w_head[DATA_MAX];
    assign RD_FRAMING_ERR = ~r_empty & w_head[DATA_MAX+1];
    assign RD_BREAK       = ~r_empty & w_head[DATA_MAX+2];
    assign EMPTY          = r_empty;
    assign FULL           = r_full;
    assign LEVEL          = r_level;
    assign OVERFLOW       = r_ovf;
    assign TIMEOUT        = r_tmo;
    assign w_thr          = (THRESHOLD == '0) ? LW'(1) : THRESHOLD;
    assign RXRDY          = ~r_empty & ((r_level >= w_thr) | r_tmo);
endmodule
